accum_hex_n: RTL and testbench
==============================

Name: accum_hex_n

Overview:
- Parametrised, two-stage registered accumulator; successor to the team's fixed 8-bit add-only accumulator.
- Adds: WIDTH generalisation, add/subtract mode, direct load and synchronous clear.
- Adds correct signed overflow, unsigned carry/borrow with optional sticky flags, and a saturating operation counter.
- Provides full 0-F hex 7-segment decode of the captured operand and of the accumulator. Sits between board switches/keys and the HEX displays.

Parameters:
- WIDTH, 8, datapath width in bits; a multiple of 4, range 4..32. DIGITS = WIDTH/4.
- STICKY, 1; 1 = CARRY/OVERFLOW hold at 1 until CLR or reset; 0 = they reflect the last operation only.
- CNT_W, 8, width of OP_COUNT.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- IN  in  WIDTH  operand.
- EN  in  1  request an accumulate operation using IN/OP this cycle.
- OP  in  1  0 = add, 1 = subtract (ACC - IN).
- LOAD  in  1  load IN into the accumulator; no arithmetic.
- CLR  in  1  synchronous clear.
- SUM  out  WIDTH  accumulator register.
- CARRY  out  1  add: carry-out; sub: borrow (1 when ACC < IN unsigned).
- OVERFLOW  out  1  two's-complement overflow.
- OP_COUNT  out  CNT_W  number of accepted EN operations, saturating.
- IN_HEX  out  7*DIGITS  segments of the captured operand; digit i at [7i+6:7i]; digit 0 = LSB nibble.
- SUM_HEX  out  7*DIGITS  segments of SUM, same packing.

Behaviour:
- Reset (RESET=0, asynchronous):
  - All registers clear: stage-1 operand and controls, SUM, CARRY, OVERFLOW, OP_COUNT.
  - IN_HEX and SUM_HEX therefore show all '0' digits (1000000).
  - Release is synchronous to CLK; the first capture happens on the first rising edge after release.
- Stage 1, every edge: register IN -> IN_R, OP -> OP_R, EN -> EN_R, LOAD -> LOAD_R, CLR -> CLR_R.
- Stage 2, every edge, applied in priority order:
  - CLR_R: SUM=0, CARRY=0, OVERFLOW=0, OP_COUNT=0.
  - LOAD_R: SUM=IN_R; flags and counter unchanged.
  - EN_R, add: {c,SUM} = SUM + IN_R at WIDTH+1 bits; CARRY=c; OVERFLOW = (SUM[MSB]==IN_R[MSB]) && (result[MSB]!=SUM[MSB]).
  - EN_R, sub: SUM = SUM - IN_R modulo 2^WIDTH; CARRY = borrow; OVERFLOW = (SUM[MSB]!=IN_R[MSB]) && (result[MSB]!=SUM[MSB]).
  - Otherwise: hold all state.
- Latency: inputs sampled at edge k take effect on SUM and flags at edge k+1. SUM_HEX follows SUM combinationally.
- Sticky flags (STICKY=1): new flag = old | computed. Only CLR_R or reset clears them.
- OP_COUNT increments on every EN_R cycle that is not overridden by CLR_R or LOAD_R, and saturates at 2^CNT_W-1 (no wrap).
- Simultaneous controls: CLR beats LOAD beats EN. Overridden requests are dropped, not queued.
- Wrap-around: SUM wraps modulo 2^WIDTH and is never saturated; only the flags report the event.
- Reset asserted mid-operation: any in-flight stage-1 operation is discarded.
- Hex decode: active-low, bit order gfedcba.
  - Digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Letters: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - Fully combinational with a default arm; no latches.

Decomposition:
- Shared package holds:
  - OP_ADD=0 and OP_SUB=1 constants.
  - The 16 segment-pattern constants.
  - The DIGITS derivation helper.
- One sub-module, hex7seg_dec (4-bit in, 7-bit out), instantiated 2*DIGITS times via generate.

Test Plan:
- Reset then release, no EN -> SUM=00, CARRY=0, OVERFLOW=0, OP_COUNT=0, SUM_HEX=1000000_1000000.
- WIDTH=8, STICKY=0: LOAD 0x7F, then EN add IN=0x01 -> one cycle later SUM=0x80, OVERFLOW=1, CARRY=0, OP_COUNT=1.
- Load 0xFF, add 0x01 -> SUM=0x00, CARRY=1, OVERFLOW=0. Next add 0x01 -> SUM=0x01, CARRY=0 (STICKY=0). Same sequence with STICKY=1 -> CARRY stays 1 until CLR.
- Subtract, each case after CLR/LOAD:
  - ACC=0x00, sub 0x01 -> SUM=0xFF, CARRY(borrow)=1, OVERFLOW=0.
  - ACC=0x80, sub 0x01 -> SUM=0x7F, OVERFLOW=1, CARRY=0.
- Same edge: CLR=1, LOAD=1, EN=1 -> SUM=0, flags 0, OP_COUNT=0. Then LOAD=1 with EN=1, IN=0x9A -> SUM=0x9A, OP_COUNT unchanged, SUM_HEX=0010000_0001000 ("9A").
- WIDTH=16: 300 consecutive EN adds of 1 -> SUM=0x012C, OP_COUNT=255 (saturated). Pulse RESET low mid-stream -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/accum_hex_n_pkg.sv
// accum_hex_n_pkg: op codes, active-low gfedcba segment patterns and digit-count helper shared by accum_hex_n
package accum_hex_n_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;
  function automatic int digits(input int width);
    return width / 4;
  endfunction
endpackage

// File: rtl/accum_hex_n_hex7seg_dec.sv
// hex7seg_dec: nibble (nib) to active-low gfedcba 7-segment pattern (seg), covers 0-F
module hex7seg_dec
  import accum_hex_n_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_0;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end
endmodule

// File: rtl/accum_hex_n.sv
// accum_hex_n: two-stage add/sub/load/clear accumulator with carry/overflow flags, saturating op counter and hex display of captured operand (IN_HEX) and SUM (SUM_HEX); CLK, async active-low RESET
module accum_hex_n
  import accum_hex_n_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STICKY = 1,
  parameter int CNT_W  = 8
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [WIDTH-1:0]             IN,
  input  logic                         EN,
  input  logic                         OP,
  input  logic                         LOAD,
  input  logic                         CLR,
  output logic [WIDTH-1:0]             SUM,
  output logic                         CARRY,
  output logic                         OVERFLOW,
  output logic [CNT_W-1:0]             OP_COUNT,
  output logic [7*digits(WIDTH)-1:0]   IN_HEX,
  output logic [7*digits(WIDTH)-1:0]   SUM_HEX
);
  localparam int DIGITS = digits(WIDTH);
  logic [WIDTH-1:0] in_r;
  logic op_r, en_r, load_r, clr_r;
  logic [WIDTH:0] res;
  logic carry_n, ovf_n;
  always_comb begin
    res = op_r == OP_ADD ? {1'b0, SUM} + {1'b0, in_r} : {1'b0, SUM} - {1'b0, in_r};
    carry_n = res[WIDTH];
    ovf_n = (op_r == OP_ADD ? SUM[WIDTH-1] == in_r[WIDTH-1] : SUM[WIDTH-1] != in_r[WIDTH-1])
            && res[WIDTH-1] != SUM[WIDTH-1];
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      in_r     <= '0;
      op_r     <= 1'b0;
      en_r     <= 1'b0;
      load_r   <= 1'b0;
      clr_r    <= 1'b0;
      SUM      <= '0;
      CARRY    <= 1'b0;
      OVERFLOW <= 1'b0;
      OP_COUNT <= '0;
    end else begin
      in_r   <= IN;
      op_r   <= OP;
      en_r   <= EN;
      load_r <= LOAD;
      clr_r  <= CLR;
      if (clr_r) begin
        SUM      <= '0;
        CARRY    <= 1'b0;
        OVERFLOW <= 1'b0;
        OP_COUNT <= '0;
      end else if (load_r) begin
        SUM <= in_r;
      end else if (en_r) begin
        SUM      <= res[WIDTH-1:0];
        CARRY    <= carry_n | (STICKY != 0 && CARRY);
        OVERFLOW <= ovf_n | (STICKY != 0 && OVERFLOW);
        OP_COUNT <= &OP_COUNT ? OP_COUNT : OP_COUNT + CNT_W'(1);
      end
    end
  end
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    hex7seg_dec u_in  (.nib(in_r[4*i +: 4]), .seg(IN_HEX[7*i +: 7]));
    hex7seg_dec u_sum (.nib(SUM[4*i +: 4]),  .seg(SUM_HEX[7*i +: 7]));
  end
endmodule

// File: tb/tb_accum_hex_n.sv
// tb_accum_hex_n: scoreboard bench over three configs (W8 non-sticky, W8 sticky, W16 sticky)
module tb_accum_hex_n;
  logic CLK, RESET, en, op, load, clr;
  logic [15:0] in_v;
  logic [7:0] sum_a, sum_b, cnt_a, cnt_b, cnt_c;
  logic [15:0] sum_c;
  logic carry_a, carry_b, carry_c, ovf_a, ovf_b, ovf_c;
  logic [13:0] in_hex_a, in_hex_b, sum_hex_a, sum_hex_b;
  logic [27:0] in_hex_c, sum_hex_c;
  typedef struct packed {
    logic [2:0][15:0] sum;
    logic [2:0]       c;
    logic [2:0]       v;
    logic [2:0][7:0]  cnt;
  } exp_t;
  exp_t q[$];
  int m_sum[3], m_c[3], m_v[3], m_cnt[3];
  int last_in, n_checks, n_fail;
  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  accum_hex_n #(.WIDTH(8), .STICKY(0), .CNT_W(8)) u_a (
    .CLK(CLK), .RESET(RESET), .IN(in_v[7:0]), .EN(en), .OP(op), .LOAD(load), .CLR(clr),
    .SUM(sum_a), .CARRY(carry_a), .OVERFLOW(ovf_a), .OP_COUNT(cnt_a),
    .IN_HEX(in_hex_a), .SUM_HEX(sum_hex_a));
  accum_hex_n #(.WIDTH(8), .STICKY(1), .CNT_W(8)) u_b (
    .CLK(CLK), .RESET(RESET), .IN(in_v[7:0]), .EN(en), .OP(op), .LOAD(load), .CLR(clr),
    .SUM(sum_b), .CARRY(carry_b), .OVERFLOW(ovf_b), .OP_COUNT(cnt_b),
    .IN_HEX(in_hex_b), .SUM_HEX(sum_hex_b));
  accum_hex_n #(.WIDTH(16), .STICKY(1), .CNT_W(8)) u_c (
    .CLK(CLK), .RESET(RESET), .IN(in_v), .EN(en), .OP(op), .LOAD(load), .CLR(clr),
    .SUM(sum_c), .CARRY(carry_c), .OVERFLOW(ovf_c), .OP_COUNT(cnt_c),
    .IN_HEX(in_hex_c), .SUM_HEX(sum_hex_c));
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [27:0] hexw(input int v, input int digs);
    logic [27:0] r;
    r = '0;
    for (int d = 0; d < digs; d++) r[7*d +: 7] = seg_tab[(v >> (4*d)) & 15];
    return r;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_sum[k] = 0; m_c[k] = 0; m_v[k] = 0; m_cnt[k] = 0;
    end
  endtask
  task automatic model(input int i, input bit e, input bit o, input bit l, input bit c);
    int w, md, half, a, b, sa, sb, r;
    bit cc, vv;
    for (int k = 0; k < 3; k++) begin
      w = k == 2 ? 16 : 8;
      md = 1 << w;
      half = md / 2;
      a = m_sum[k];
      b = i % md;
      if (c) begin
        m_sum[k] = 0; m_c[k] = 0; m_v[k] = 0; m_cnt[k] = 0;
      end else if (l) begin
        m_sum[k] = b;
      end else if (e) begin
        sa = a >= half ? a - md : a;
        sb = b >= half ? b - md : b;
        r = o ? sa - sb : sa + sb;
        vv = r >= half || r < -half;
        cc = o ? a < b : a + b >= md;
        m_sum[k] = o ? (a - b + md) % md : (a + b) % md;
        m_c[k] = int'(cc) | (k != 0 ? m_c[k] : 0);
        m_v[k] = int'(vv) | (k != 0 ? m_v[k] : 0);
        m_cnt[k] = m_cnt[k] < 255 ? m_cnt[k] + 1 : 255;
      end
    end
  endtask
  task automatic inst(input string n, input int k, input exp_t x, input logic [15:0] s,
                      input logic cy, input logic ov, input logic [7:0] ct, input logic [27:0] hx);
    check({"sum_", n}, s, x.sum[k]);
    check({"carry_", n}, cy, x.c[k]);
    check({"ovf_", n}, ov, x.v[k]);
    check({"cnt_", n}, ct, x.cnt[k]);
    check({"sum_hex_", n}, hx, hexw(x.sum[k], k == 2 ? 4 : 2));
  endtask
  task automatic compare(input exp_t x);
    inst("a", 0, x, 16'(sum_a), carry_a, ovf_a, cnt_a, 28'(sum_hex_a));
    inst("b", 1, x, 16'(sum_b), carry_b, ovf_b, cnt_b, 28'(sum_hex_b));
    inst("c", 2, x, sum_c, carry_c, ovf_c, cnt_c, sum_hex_c);
  endtask
  task automatic zero_all(input string tag);
    exp_t z;
    z = '0;
    compare(z);
    check({tag, "_in_hex_a"}, 28'(in_hex_a), hexw(0, 2));
    check({tag, "_in_hex_c"}, in_hex_c, hexw(0, 4));
  endtask
  task automatic step(input int i, input bit e, input bit o, input bit l, input bit c);
    exp_t x;
    @(negedge CLK);
    if (q.size() == 2) compare(q.pop_front());
    check("in_hex_a", 28'(in_hex_a), hexw(last_in & 255, 2));
    check("in_hex_b", 28'(in_hex_b), hexw(last_in & 255, 2));
    check("in_hex_c", in_hex_c, hexw(last_in & 65535, 4));
    in_v = 16'(i); en = e; op = o; load = l; clr = c;
    last_in = i;
    model(i, e, o, l, c);
    for (int k = 0; k < 3; k++) begin
      x.sum[k] = 16'(m_sum[k]); x.c[k] = m_c[k][0]; x.v[k] = m_v[k][0]; x.cnt[k] = 8'(m_cnt[k]);
    end
    q.push_back(x);
  endtask
  task automatic idle2();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask
  initial begin
    CLK = 0; RESET = 0; in_v = '0; en = 0; op = 0; load = 0; clr = 0;
    last_in = 0; n_checks = 0; n_fail = 0;
    model_reset();
    repeat (2) @(negedge CLK);
    zero_all("rst");
    check("rst_hex_const", 28'(sum_hex_a), 28'(14'b1000000_1000000));
    RESET = 1;
    step(8'h7F, 0, 0, 1, 0); step(1, 1, 0, 0, 0); idle2();
    check("ovf_7f_sum", 16'(sum_a), 16'h80);
    check("ovf_7f_v", ovf_a, 1'b1);
    check("ovf_7f_cnt", cnt_a, 8'd1);
    step(8'hFF, 0, 0, 1, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); idle2();
    check("wrap_sum", 16'(sum_a), 16'h01);
    check("wrap_carry_ns", carry_a, 1'b0);
    check("wrap_carry_st", carry_b, 1'b1);
    step(0, 0, 0, 0, 1); idle2();
    check("clr_carry_st", carry_b, 1'b0);
    step(1, 1, 1, 0, 0); idle2();
    check("borrow_sum", 16'(sum_a), 16'hFF);
    check("borrow_c", carry_a, 1'b1);
    step(8'h80, 0, 0, 1, 0); step(1, 1, 1, 0, 0); idle2();
    check("sub_ovf_sum", 16'(sum_a), 16'h7F);
    check("sub_ovf_v", ovf_a, 1'b1);
    step(8'h55, 1, 0, 1, 1); step(8'h9A, 1, 0, 1, 0); idle2();
    check("prio_sum", 16'(sum_a), 16'h9A);
    check("prio_cnt", cnt_a, 8'd0);
    check("prio_hex", 28'(sum_hex_a), 28'(14'b0010000_0001000));
    step(0, 0, 0, 0, 1);
    repeat (300) step(1, 1, 0, 0, 0);
    idle2();
    check("sat_sum", sum_c, 16'h012C);
    check("sat_cnt", cnt_c, 8'd255);
    repeat (5) step(1, 1, 0, 0, 0);
    #2;
    RESET = 0; in_v = '0; en = 0; op = 0; load = 0; clr = 0;
    #1;
    zero_all("async");
    q.delete();
    model_reset();
    last_in = 0;
    @(negedge CLK);
    RESET = 1;
    step(16'h1234, 0, 0, 1, 0); step(5, 1, 1, 0, 0); step(16'hFFFF, 1, 0, 0, 0);
    idle2();
    step(0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
